// File: rtl/iob_mondo_pkg.sv
// Shared definitions for the IOB mondo receiver: FSM state encoding,
// packet geometry and the field layout of a mondo data table entry.
package iob_mondo_pkg;

  // One-hot receiver states
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_HDR1  = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_CHECK = 5'b01000,
    ST_INT   = 5'b10000
  } mondo_state_e;

  localparam int MONDO_BEATS   = 18;
  localparam int HDR_BEATS     = 2;
  localparam int PAYLOAD_BEATS = MONDO_BEATS - HDR_BEATS;
  localparam int RSV_W         = 3;
  localparam int PAYLOAD_W     = 128;

  // mdt_wdata = {agtid, payload}
  localparam int MDT_PAYLOAD_LSB = 0;
  localparam int MDT_AGTID_LSB   = PAYLOAD_W;

  // True when the reserved upper bits of a header beat are nonzero
  function automatic logic rsv_nonzero(input logic [7:0] beat);
    return |beat[7:8-RSV_W];
  endfunction

endpackage

// File: rtl/iob_mondo_deser.sv
// Mondo beat deserializer: captures the cpuid/agtid header beats, shifts in
// the 16 payload bytes (first byte ends up most significant) and counts
// payload beats. Optional macro IOB_MONDO_PROTO_CHK_EN enables the
// reserved-bit header error flag; otherwise that flag is tied low.
module iob_mondo_deser
  import iob_mondo_pkg::*;
#(
  parameter int ID_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hdr0_en_i,
  input  logic                 hdr1_en_i,
  input  logic                 data_en_i,
  input  logic [7:0]           beat_data_i,
  output logic [ID_W-1:0]      cpuid_o,
  output logic [ID_W-1:0]      agtid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic                 rec_done_o,
  output logic                 hdr_err_o
);

  logic [ID_W-1:0]      cpuid_q;
  logic [ID_W-1:0]      agtid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [3:0]           cnt_q;

  // Header capture, payload shift register and payload beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpuid_q   <= '0;
      agtid_q   <= '0;
      payload_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (hdr0_en_i) cpuid_q <= beat_data_i[ID_W-1:0];
      if (hdr1_en_i) begin
        agtid_q <= beat_data_i[ID_W-1:0];
        cnt_q   <= '0;
      end
      if (data_en_i) begin
        payload_q <= {payload_q[PAYLOAD_W-9:0], beat_data_i};
        cnt_q     <= cnt_q + 4'd1;
      end
    end
  end

  assign rec_done_o = data_en_i && (cnt_q == 4'(PAYLOAD_BEATS - 1));
  assign cpuid_o    = cpuid_q;
  assign agtid_o    = agtid_q;
  assign payload_o  = payload_q;

`ifdef IOB_MONDO_PROTO_CHK_EN
  logic hdr_err_q;

  // Header error: beat 0 restarts the flag, beat 1 accumulates into it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_err_q <= 1'b0;
    end else if (hdr0_en_i) begin
      hdr_err_q <= rsv_nonzero(beat_data_i);
    end else if (hdr1_en_i) begin
      hdr_err_q <= hdr_err_q | rsv_nonzero(beat_data_i);
    end
  end

  assign hdr_err_o = hdr_err_q;
`else
  assign hdr_err_o = 1'b0;
`endif

endmodule

// File: rtl/iob_jbi_mondo_rcv.sv
// IOB-side JBI mondo receiver: deserializes an 18-beat mondo, checks the
// target CPU's busy bit, writes accepted records into the mondo data table,
// requests an interrupt and answers JBI with a one-cycle ack or nack.
// Optional macro IOB_MONDO_PROTO_CHK_EN adds protocol checking (reserved
// header bits, stream gaps, stray beats) with a proto_err pulse.
module iob_jbi_mondo_rcv
  import iob_mondo_pkg::*;
#(
  parameter int NUM_CPU = 32,
  parameter int ID_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      jbi_iob_mondo_vld,
  input  logic [7:0]                jbi_iob_mondo_data,
  output logic                      iob_jbi_mondo_ack,
  output logic                      iob_jbi_mondo_nack,
  output logic                      mdt_wr_en,
  output logic [ID_W-1:0]           mdt_waddr,
  output logic [PAYLOAD_W+ID_W-1:0] mdt_wdata,
  output logic                      mondo_int_vld,
  output logic [ID_W-1:0]           mondo_int_cpuid,
  input  logic                      mondo_int_rdy,
  input  logic                      busy_clr,
  input  logic [ID_W-1:0]           busy_clr_cpuid,
  output logic [NUM_CPU-1:0]        busy_vec,
  output logic                      proto_err
);

  mondo_state_e         state_q;
  logic                 ack_q;
  logic                 nack_q;
  logic                 int_vld_q;
  logic [NUM_CPU-1:0]   busy_q;
  logic [NUM_CPU-1:0]   busy_d;
  logic [NUM_CPU-1:0]   sel_mask;
  logic [NUM_CPU-1:0]   clr_mask;
  logic                 hdr0_en;
  logic                 hdr1_en;
  logic                 data_en;
  logic                 rec_done;
  logic                 hdr_err;
  logic [ID_W-1:0]      cpuid;
  logic [ID_W-1:0]      agtid;
  logic [PAYLOAD_W-1:0] payload;
  logic                 in_check;
  logic                 cpu_in_range;
  logic                 busy_hit;
  logic                 reject;
  logic                 accept;

  assign hdr0_en  = (state_q == ST_IDLE) && jbi_iob_mondo_vld;
  assign hdr1_en  = (state_q == ST_HDR1) && jbi_iob_mondo_vld;
  assign data_en  = (state_q == ST_DATA) && jbi_iob_mondo_vld;
  assign in_check = (state_q == ST_CHECK);

  iob_mondo_deser #(
    .ID_W (ID_W)
  ) u_deser (
    .clk         (clk),
    .rst         (rst),
    .hdr0_en_i   (hdr0_en),
    .hdr1_en_i   (hdr1_en),
    .data_en_i   (data_en),
    .beat_data_i (jbi_iob_mondo_data),
    .cpuid_o     (cpuid),
    .agtid_o     (agtid),
    .payload_o   (payload),
    .rec_done_o  (rec_done),
    .hdr_err_o   (hdr_err)
  );

  // Decode the target cpu and the software clear into per-cpu masks;
  // ids at or above NUM_CPU match no bit and so fall out naturally
  always_comb begin
    sel_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      sel_mask[i] = (cpuid == ID_W'(i));
      clr_mask[i] = busy_clr && (busy_clr_cpuid == ID_W'(i));
    end
  end

  // The busy check sees a same-cycle clear; an accept then re-sets the bit
  assign cpu_in_range = |sel_mask;
  assign busy_hit     = |(busy_q & ~clr_mask & sel_mask);
  assign reject       = !cpu_in_range || busy_hit || hdr_err;
  assign accept       = in_check && !reject;
  assign busy_d       = (busy_q & ~clr_mask) | (accept ? sel_mask : '0);

  // Per-cpu receive-busy bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Receive FSM with registered ack/nack/interrupt-request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      int_vld_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (jbi_iob_mondo_vld) state_q <= ST_HDR1;
        end
        ST_HDR1: begin
          if (jbi_iob_mondo_vld) begin
            state_q <= ST_DATA;
          end
`ifdef IOB_MONDO_PROTO_CHK_EN
          else begin
            nack_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
`endif
        end
        ST_DATA: begin
          if (rec_done) begin
            state_q <= ST_CHECK;
          end
`ifdef IOB_MONDO_PROTO_CHK_EN
          else if (!jbi_iob_mondo_vld) begin
            nack_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
`endif
        end
        ST_CHECK: begin
          if (reject) begin
            nack_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            int_vld_q <= 1'b1;
            state_q   <= ST_INT;
          end
        end
        ST_INT: begin
          if (mondo_int_rdy) begin
            int_vld_q <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          int_vld_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IOB_MONDO_PROTO_CHK_EN
  logic perr_q;

  // Protocol error: stream gap mid-packet, stray beat while busy, bad header
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= (((state_q == ST_HDR1) || (state_q == ST_DATA)) && !jbi_iob_mondo_vld)
             || (((state_q == ST_CHECK) || (state_q == ST_INT)) && jbi_iob_mondo_vld)
             || (in_check && hdr_err);
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

  assign iob_jbi_mondo_ack  = ack_q;
  assign iob_jbi_mondo_nack = nack_q;
  assign mondo_int_vld      = int_vld_q;
  assign mondo_int_cpuid    = cpuid;
  assign mdt_wr_en          = accept;
  assign mdt_waddr          = cpuid;
  assign mdt_wdata          = {agtid, payload};
  assign busy_vec           = busy_q;

endmodule

// File: tb/tb_iob_jbi_mondo_rcv.sv
// Self-checking bench for iob_jbi_mondo_rcv (NUM_CPU=16 so that high cpuids
// are out of range). Expected results come from a per-mondo model: a busy
// bit array plus the accept/reject rule applied to each generated record.
module tb_iob_jbi_mondo_rcv;

  localparam int NCPU = 16;
  localparam int IDW  = 5;

  logic             clk;
  logic             rst;
  logic             jbi_iob_mondo_vld;
  logic [7:0]       jbi_iob_mondo_data;
  logic             iob_jbi_mondo_ack;
  logic             iob_jbi_mondo_nack;
  logic             mdt_wr_en;
  logic [IDW-1:0]   mdt_waddr;
  logic [128+IDW-1:0] mdt_wdata;
  logic             mondo_int_vld;
  logic [IDW-1:0]   mondo_int_cpuid;
  logic             mondo_int_rdy;
  logic             busy_clr;
  logic [IDW-1:0]   busy_clr_cpuid;
  logic [NCPU-1:0]  busy_vec;
  logic             proto_err;

  int errors = 0;
  int checks = 0;
  logic [NCPU-1:0] busy_m;

`ifdef IOB_MONDO_PROTO_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  iob_jbi_mondo_rcv #(
    .NUM_CPU (NCPU),
    .ID_W    (IDW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .jbi_iob_mondo_vld  (jbi_iob_mondo_vld),
    .jbi_iob_mondo_data (jbi_iob_mondo_data),
    .iob_jbi_mondo_ack  (iob_jbi_mondo_ack),
    .iob_jbi_mondo_nack (iob_jbi_mondo_nack),
    .mdt_wr_en          (mdt_wr_en),
    .mdt_waddr          (mdt_waddr),
    .mdt_wdata          (mdt_wdata),
    .mondo_int_vld      (mondo_int_vld),
    .mondo_int_cpuid    (mondo_int_cpuid),
    .mondo_int_rdy      (mondo_int_rdy),
    .busy_clr           (busy_clr),
    .busy_clr_cpuid     (busy_clr_cpuid),
    .busy_vec           (busy_vec),
    .proto_err          (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [139:0] got, input logic [139:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] b);
    jbi_iob_mondo_vld  = 1'b1;
    jbi_iob_mondo_data = b;
    next_cycle();
    jbi_iob_mondo_vld  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_ack"},  iob_jbi_mondo_ack, 1'b0);
    check({tag, "_nack"}, iob_jbi_mondo_nack, 1'b0);
    check({tag, "_wr"},   mdt_wr_en, 1'b0);
    check({tag, "_int"},  mondo_int_vld, 1'b0);
    check({tag, "_perr"}, proto_err, 1'b0);
  endtask

  task automatic idle_clr(input logic [4:0] c);
    busy_clr       = 1'b1;
    busy_clr_cpuid = c;
    next_cycle();
    busy_clr = 1'b0;
    if (c < NCPU) busy_m[c] = 1'b0;
    @(negedge clk);
    check("idle_clr_busy", busy_vec, busy_m);
  endtask

  // One complete mondo exchange, including the expected response timing
  task automatic run_mondo(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [127:0] pl, input int gap_at, input int gap_len,
                           input bit do_clr, input logic [4:0] clr_cpu,
                           input int rdy_dly, input bit stray);
    logic [4:0] cpu;
    bit herr, in_rng, eff_busy, acc, exp_perr;
    cpu  = b0[4:0];
    herr = CHK_EN && ((b0[7:5] != 3'b0) || (b1[7:5] != 3'b0));
    send_beat(b0);
    send_beat(b1);
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at && gap_len > 0) begin
        if (CHK_EN) begin
          next_cycle();
          @(negedge clk);
          check("gap_nack", iob_jbi_mondo_nack, 1'b1);
          check("gap_perr", proto_err, 1'b1);
          check("gap_busy", busy_vec, busy_m);
          next_cycle();
          @(negedge clk);
          check("gap_nack_end", iob_jbi_mondo_nack, 1'b0);
          next_cycle();
          return;
        end
        repeat (gap_len) next_cycle();
      end
      send_beat(pl[127-8*k -: 8]);
    end
    // cycle N+1: CHECK
    if (do_clr) begin
      busy_clr       = 1'b1;
      busy_clr_cpuid = clr_cpu;
    end
    if (stray) begin
      jbi_iob_mondo_vld  = 1'b1;
      jbi_iob_mondo_data = 8'($urandom);
    end
    in_rng   = (cpu < NCPU);
    eff_busy = in_rng && busy_m[cpu[3:0]] && !(do_clr && clr_cpu == cpu);
    acc      = in_rng && !eff_busy && !herr;
    exp_perr = herr || (CHK_EN && stray);
    @(negedge clk);
    check("mdt_wr_en", mdt_wr_en, acc);
    if (acc) begin
      check("mdt_waddr", mdt_waddr, cpu);
      check("mdt_wdata", mdt_wdata, {b1[4:0], pl});
    end
    check("nack_early", iob_jbi_mondo_nack, 1'b0);
    if (do_clr && clr_cpu < NCPU) busy_m[clr_cpu[3:0]] = 1'b0;
    if (acc) busy_m[cpu[3:0]] = 1'b1;
    // cycle N+2
    next_cycle();
    busy_clr      = 1'b0;
    mondo_int_rdy = (rdy_dly == 0);
    jbi_iob_mondo_vld  = stray && acc;
    jbi_iob_mondo_data = 8'($urandom);
    @(negedge clk);
    check("busy_vec", busy_vec, busy_m);
    if (!acc) begin
      check("rej_nack", iob_jbi_mondo_nack, 1'b1);
      check("rej_int", mondo_int_vld, 1'b0);
      check("rej_ack", iob_jbi_mondo_ack, 1'b0);
      check("rej_perr", proto_err, exp_perr);
      next_cycle();
      @(negedge clk);
      check("rej_nack_end", iob_jbi_mondo_nack, 1'b0);
      next_cycle();
    end else begin
      check("int_vld", mondo_int_vld, 1'b1);
      check("int_cpuid", mondo_int_cpuid, cpu);
      check("acc_nack", iob_jbi_mondo_nack, 1'b0);
      check("acc_ack_early", iob_jbi_mondo_ack, 1'b0);
      for (int d = 1; d <= rdy_dly; d++) begin
        next_cycle();
        if (d == rdy_dly) begin
          mondo_int_rdy     = 1'b1;
          jbi_iob_mondo_vld = 1'b0;
        end else begin
          jbi_iob_mondo_vld  = stray;
          jbi_iob_mondo_data = 8'($urandom);
        end
        @(negedge clk);
        check("int_held", mondo_int_vld, 1'b1);
        check("ack_held_low", iob_jbi_mondo_ack, 1'b0);
      end
      next_cycle();
      jbi_iob_mondo_vld = 1'b0;
      @(negedge clk);
      check("ack_pulse", iob_jbi_mondo_ack, 1'b1);
      check("int_drop", mondo_int_vld, 1'b0);
      next_cycle();
      @(negedge clk);
      check("ack_end", iob_jbi_mondo_ack, 1'b0);
      next_cycle();
    end
    mondo_int_rdy = 1'b1;
  endtask

  function automatic logic [127:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pl_inc;
    logic [4:0]   cpu;
    logic [4:0]   cc;
    int           gat, glen;
    bit           dclr;

    rst                = 1'b1;
    jbi_iob_mondo_vld  = 1'b0;
    jbi_iob_mondo_data = 8'h00;
    mondo_int_rdy      = 1'b1;
    busy_clr           = 1'b0;
    busy_clr_cpuid     = '0;
    busy_m             = '0;

    repeat (2) next_cycle();
    check_idle_outputs("reset");
    check("reset_busy", busy_vec, '0);
    check("reset_waddr", mdt_waddr, '0);
    check("reset_wdata", mdt_wdata, '0);
    check("reset_icpu", mondo_int_cpuid, '0);
    rst = 1'b0;
    next_cycle();

    for (int k = 0; k < 16; k++) pl_inc[127-8*k -: 8] = 8'(k);

    // Accept path
    run_mondo(8'h03, 8'h1F, pl_inc, -1, 0, 1'b0, 5'd0, 0, 1'b0);
    // Busy nack, then same cpu with a clear in the CHECK cycle
    run_mondo(8'h03, 8'h02, rand_payload(), -1, 0, 1'b0, 5'd0, 0, 1'b0);
    run_mondo(8'h03, 8'h04, rand_payload(), -1, 0, 1'b1, 5'd3, 0, 1'b0);
    // Backpressure with stray beats
    run_mondo(8'h05, 8'h11, rand_payload(), -1, 0, 1'b0, 5'd0, 5, 1'b1);
    // Out-of-range cpuid
    run_mondo(8'h1F, 8'h01, rand_payload(), -1, 0, 1'b0, 5'd0, 0, 1'b0);
    // Stream gap mid-payload
    run_mondo(8'h07, 8'h0A, rand_payload(), 6, 3, 1'b0, 5'd0, 0, 1'b0);
    // Reserved bit in beat 1 (only an error with protocol checking)
    run_mondo(8'h08, 8'h29, rand_payload(), -1, 0, 1'b0, 5'd0, 0, 1'b0);
    check_idle_outputs("post_directed");

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle_clr(5'($urandom_range(0, 31)));
      cpu  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      dclr = ($urandom_range(0, 3) == 0);
      cc   = ($urandom_range(0, 1) == 0) ? cpu : 5'($urandom_range(0, 31));
      gat  = $urandom_range(0, 15);
      glen = CHK_EN ? 0 : $urandom_range(0, 3);
      run_mondo({3'b000, cpu}, {3'b000, 5'($urandom)}, rand_payload(), gat, glen,
                dclr, cc, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of DATA
    send_beat(8'h02);
    send_beat(8'h03);
    for (int k = 0; k < 5; k++) send_beat(8'($urandom));
    rst = 1'b1;
    busy_m = '0;
    @(negedge clk);
    check("rst_mid_ack", iob_jbi_mondo_ack, 1'b0);
    check("rst_mid_nack", iob_jbi_mondo_nack, 1'b0);
    check("rst_mid_wr", mdt_wr_en, 1'b0);
    check("rst_mid_int", mondo_int_vld, 1'b0);
    check("rst_mid_busy", busy_vec, '0);
    check("rst_mid_wdata", mdt_wdata, '0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check_idle_outputs("after_rst");
    run_mondo(8'h02, 8'h15, rand_payload(), -1, 0, 1'b0, 5'd0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
